// File: rtl/dmc_dma.sv
// DMA responder for the APU delta-modulation channel: halts the CPU, runs the
// halt/dummy/align cycles, masters one sample read and strobes the byte back to the DMC.
module dmc_dma #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce,
  input  logic              apu_cycle,
  input  logic [4:0]        apu_addr,
  input  logic              apu_wr,
  input  logic [7:0]        data_from_cpu,
  input  logic              dma_init,
  input  logic              dma_req,
  input  logic              cpu_rw,
  output logic              cpu_rdy,
  output logic              dma_active,
  output logic              dma_rd,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              dmc_read
);

  // The halt cycle has no state of its own: PEND ends on the first CPU read cycle.
  typedef enum logic [2:0] {StIdle, StPend, StDummy, StAlign, StRead} state_e;

  state_e            state_q, state_d;
  logic [7:0]        reg4012_q, reg4012_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              en_clr;

  assign en_clr = apu_wr && (apu_addr == 5'h15) && !data_from_cpu[4];

  always_comb begin
    state_d    = state_q;
    cpu_rdy    = 1'b1;
    dma_active = 1'b0;
    dma_rd     = 1'b0;
    dmc_read   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dma_req) state_d = StPend;
      end
      StPend: begin
        cpu_rdy = 1'b0;
        if (en_clr) begin
          state_d = StIdle;
        end else if (cpu_ce && cpu_rw) begin
          state_d = StDummy;
        end
      end
      StDummy: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        // A get here means the next cycle is a put, so one alignment cycle is needed.
        if (cpu_ce) state_d = apu_cycle ? StRead : StAlign;
      end
      StAlign: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        if (cpu_ce) state_d = StRead;
      end
      StRead: begin
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        dma_rd     = 1'b1;
        if (cpu_ce) begin
          dmc_read = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    reg4012_d  = reg4012_q;
    cur_addr_d = cur_addr_q;
    if (apu_wr && (apu_addr == 5'h12)) reg4012_d = data_from_cpu;
    if (dma_init) begin
      cur_addr_d = ADDR_W'({2'b11, reg4012_q, 6'b0});
    end else if (dmc_read) begin
      cur_addr_d = (cur_addr_q == '1) ? ADDR_W'(16'h8000) : cur_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      reg4012_q  <= 8'h00;
      cur_addr_q <= ADDR_W'(16'hC000);
    end else begin
      state_q    <= state_d;
      reg4012_q  <= reg4012_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  assign dma_addr = cur_addr_q;

endmodule

// File: tb/tb_dmc_dma.sv
// Directed bench for dmc_dma: reset, address load, fetch latency, write stall,
// wrap-around, init collision, cancellation and ignored requests.
module tb_dmc_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce;
  logic        apu_cycle;
  logic [4:0]  apu_addr;
  logic        apu_wr;
  logic [7:0]  data_from_cpu;
  logic        dma_init;
  logic        dma_req;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic        dma_active;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic        dmc_read;

  int n_vec = 0;
  int n_err = 0;

  dmc_dma #(.ADDR_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_ce       (cpu_ce),
    .apu_cycle    (apu_cycle),
    .apu_addr     (apu_addr),
    .apu_wr       (apu_wr),
    .data_from_cpu(data_from_cpu),
    .dma_init     (dma_init),
    .dma_req      (dma_req),
    .cpu_rw       (cpu_rw),
    .cpu_rdy      (cpu_rdy),
    .dma_active   (dma_active),
    .dma_rd       (dma_rd),
    .dma_addr     (dma_addr),
    .dmc_read     (dmc_read)
  );

  always #5 clk = ~clk;

  task automatic clear_strobes();
    cpu_ce   = 1'b0;
    dma_req  = 1'b0;
    apu_wr   = 1'b0;
    dma_init = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    clear_strobes();
    apu_wr        = 1'b1;
    apu_addr      = a;
    data_from_cpu = d;
    @(negedge clk);
    clear_strobes();
    #1;
  endtask

  task automatic pulse_init();
    @(negedge clk);
    clear_strobes();
    dma_init = 1'b1;
    @(negedge clk);
    clear_strobes();
    #1;
  endtask

  // Issues one dma_req, then runs 10 CPU cycles of 3 clocks each (cpu_ce on the last).
  // nwr leading write cycles; the dummy cycle's apu_cycle is dummy_put.
  task automatic fetch(input int nwr, input bit dummy_put, input int req_at, input int clr_at,
                       input int init_at, output bit rdy_low, output int first_read,
                       output int reads, output int dummies);
    bit rw;
    bit ac;
    rdy_low    = 1'b0;
    first_read = 0;
    reads      = 0;
    dummies    = 0;
    @(negedge clk);
    clear_strobes();
    dma_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rw = (i >= nwr);
      ac = dummy_put ^ bit'((i + nwr + 1) & 1);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        clear_strobes();
        cpu_ce    = (k == 2);
        cpu_rw    = rw;
        apu_cycle = ac;
        if (i == req_at && k == 0) dma_req = 1'b1;
        if (i == clr_at && k == 0) begin
          apu_wr        = 1'b1;
          apu_addr      = 5'h15;
          data_from_cpu = 8'h00;
        end
        if (i == init_at && k == 2) dma_init = 1'b1;
        #1;
        if (i == 0 && k == 0) rdy_low = (cpu_rdy === 1'b0);
        if (dmc_read === 1'b1) begin
          reads++;
          if (first_read == 0) first_read = i + 1;
        end
        if (k == 2 && dma_active === 1'b1 && dma_rd === 1'b0) dummies++;
      end
    end
    @(negedge clk);
    clear_strobes();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy got %b want 1", cpu_rdy); end
    n_vec++; if (dma_rd !== 1'b0) begin n_err++; $display("FAIL reset_dma_rd got %b want 0", dma_rd); end
    n_vec++; if (dmc_read !== 1'b0) begin n_err++; $display("FAIL reset_dmc_read got %b want 0", dmc_read); end
    n_vec++; if (dma_active !== 1'b0) begin n_err++; $display("FAIL reset_active got %b want 0", dma_active); end
    n_vec++; if (dma_addr !== 16'hC000) begin n_err++; $display("FAIL reset_addr got %h want c000", dma_addr); end
  endtask

  task automatic test_addr_load();
    write_reg(5'h12, 8'h03);
    n_vec++; if (dma_addr !== 16'hC000) begin n_err++; $display("FAIL reg_no_reload got %h want c000", dma_addr); end
    pulse_init();
    n_vec++; if (dma_addr !== 16'hC0C0) begin n_err++; $display("FAIL load_03 got %h want c0c0", dma_addr); end
    write_reg(5'h12, 8'hFF);
    pulse_init();
    n_vec++; if (dma_addr !== 16'hFFC0) begin n_err++; $display("FAIL load_ff got %h want ffc0", dma_addr); end
  endtask

  task automatic test_fetch_put();
    bit rl; int fr, rd, dm;
    write_reg(5'h12, 8'h03);
    pulse_init();
    fetch(0, 1'b1, -1, -1, -1, rl, fr, rd, dm);
    n_vec++; if (!rl) begin n_err++; $display("FAIL put_rdy_low got high want low"); end
    n_vec++; if (fr != 3) begin n_err++; $display("FAIL put_latency got %0d want 3", fr); end
    n_vec++; if (rd != 1) begin n_err++; $display("FAIL put_reads got %0d want 1", rd); end
    n_vec++; if (dm != 1) begin n_err++; $display("FAIL put_dummy_cycles got %0d want 1", dm); end
    n_vec++; if (dma_addr !== 16'hC0C1) begin n_err++; $display("FAIL put_advance got %h want c0c1", dma_addr); end
    n_vec++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL put_release got %b want 1", cpu_rdy); end
  endtask

  task automatic test_fetch_get();
    bit rl; int fr, rd, dm;
    fetch(0, 1'b0, -1, -1, -1, rl, fr, rd, dm);
    n_vec++; if (fr != 4) begin n_err++; $display("FAIL get_latency got %0d want 4", fr); end
    n_vec++; if (dm != 2) begin n_err++; $display("FAIL get_align_seen got %0d want 2", dm); end
    n_vec++; if (dma_addr !== 16'hC0C2) begin n_err++; $display("FAIL get_advance got %h want c0c2", dma_addr); end
  endtask

  task automatic test_write_stall();
    bit rl; int fr, rd, dm;
    fetch(3, 1'b1, -1, -1, -1, rl, fr, rd, dm);
    n_vec++; if (fr != 6) begin n_err++; $display("FAIL stall_latency got %0d want 6", fr); end
    n_vec++; if (rd != 1) begin n_err++; $display("FAIL stall_reads got %0d want 1", rd); end
    n_vec++; if (dma_addr !== 16'hC0C3) begin n_err++; $display("FAIL stall_advance got %h want c0c3", dma_addr); end
  endtask

  task automatic test_cancel();
    bit rl; int fr, rd, dm;
    int  reads;
    @(negedge clk);
    clear_strobes();
    dma_req = 1'b1;
    cpu_rw  = 1'b0;
    @(negedge clk);
    clear_strobes();
    apu_wr        = 1'b1;
    apu_addr      = 5'h15;
    data_from_cpu = 8'h00;
    #1;
    n_vec++; if (cpu_rdy !== 1'b0) begin n_err++; $display("FAIL cancel_pend_low got %b want 0", cpu_rdy); end
    @(negedge clk);
    clear_strobes();
    #1;
    n_vec++; if (cpu_rdy !== 1'b1) begin n_err++; $display("FAIL cancel_release got %b want 1", cpu_rdy); end
    reads = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      clear_strobes();
      cpu_ce = (i % 3 == 2);
      cpu_rw = 1'b1;
      #1;
      if (dmc_read === 1'b1) reads++;
    end
    n_vec++; if (reads != 0) begin n_err++; $display("FAIL cancel_no_read got %0d want 0", reads); end
    n_vec++; if (dma_addr !== 16'hC0C3) begin n_err++; $display("FAIL cancel_addr got %h want c0c3", dma_addr); end
    fetch(0, 1'b1, -1, 1, -1, rl, fr, rd, dm);
    n_vec++; if (rd != 1 || fr != 3) begin
      n_err++; $display("FAIL cancel_in_dummy got reads=%0d at=%0d want 1 at 3", rd, fr);
    end
  endtask

  task automatic test_ignored_req();
    bit rl; int fr, rd, dm;
    fetch(0, 1'b1, 2, -1, -1, rl, fr, rd, dm);
    n_vec++; if (rd != 1) begin n_err++; $display("FAIL ignored_req got %0d reads want 1", rd); end
    n_vec++; if (dma_addr !== 16'hC0C5) begin n_err++; $display("FAIL ignored_addr got %h want c0c5", dma_addr); end
  endtask

  task automatic test_wrap();
    bit rl; int fr, rd, dm;
    write_reg(5'h12, 8'hFF);
    pulse_init();
    for (int n = 0; n < 63; n++) fetch(0, 1'b1, -1, -1, -1, rl, fr, rd, dm);
    n_vec++; if (dma_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_top got %h want ffff", dma_addr); end
    fetch(0, 1'b1, -1, -1, -1, rl, fr, rd, dm);
    n_vec++; if (dma_addr !== 16'h8000) begin n_err++; $display("FAIL wrap_8000 got %h want 8000", dma_addr); end
  endtask

  task automatic test_init_collision();
    bit rl; int fr, rd, dm;
    write_reg(5'h12, 8'h03);
    fetch(0, 1'b1, -1, -1, 2, rl, fr, rd, dm);
    n_vec++; if (rd != 1) begin n_err++; $display("FAIL collide_reads got %0d want 1", rd); end
    n_vec++; if (dma_addr !== 16'hC0C0) begin n_err++; $display("FAIL collide_init got %h want c0c0", dma_addr); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    clear_strobes();
    dma_req = 1'b1;
    cpu_rw  = 1'b1;
    @(negedge clk);
    clear_strobes();
    cpu_ce = 1'b1;
    @(negedge clk);
    clear_strobes();
    #1;
    n_vec++; if (dma_active !== 1'b1) begin n_err++; $display("FAIL mid_in_dummy got %b want 1", dma_active); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got rdy=%b act=%b want 1 0", cpu_rdy, dma_active);
    end
    n_vec++; if (dma_addr !== 16'hC000) begin n_err++; $display("FAIL mid_reset_addr got %h want c000", dma_addr); end
  endtask

  initial begin
    rst           = 1'b0;
    apu_cycle     = 1'b0;
    apu_addr      = 5'h00;
    data_from_cpu = 8'h00;
    cpu_rw        = 1'b1;
    clear_strobes();
    test_reset();
    test_addr_load();
    test_fetch_put();
    test_fetch_get();
    test_write_stall();
    test_cancel();
    test_ignored_req();
    test_wrap();
    test_init_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
